// File: rtl/alu_issue.sv
// Issue stage between register read and writeback. It decodes one RV32I OP, OP-IMM or BRANCH instruction,
// drives the external ALU for one cycle, and returns a writeback or branch response.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic [2:0]      o_alu_opsel,
    output logic            o_alu_sub,
    output logic            o_alu_unsigned,
    output logic            o_alu_arith,
    output logic [XLEN-1:0] o_alu_op1,
    output logic [XLEN-1:0] o_alu_op2,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic            i_alu_eq,
    input  logic            i_alu_slt,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [4:0]      o_rd_waddr,
    output logic [XLEN-1:0] o_rd_wdata,
    output logic            o_rd_wen,
    output logic            o_branch_taken,
    output logic            o_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_ALU    = 2'd1,
        CLS_BRANCH = 2'd2
    } cls_t;

    state_t          state_r;
    cls_t            cls_r;
    logic [2:0]      funct3_r;
    logic [4:0]      rd_r;
    logic            illegal_r;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    cls_t            raw_cls_s;
    logic            raw_illegal_s;
    logic [2:0]      raw_opsel_s;
    logic            raw_sub_s;
    logic            raw_unsigned_s;
    logic            raw_arith_s;
    logic [XLEN-1:0] raw_op1_s;
    logic [XLEN-1:0] raw_op2_s;

    logic [2:0]      dec_opsel_s;
    logic            dec_sub_s;
    logic            dec_unsigned_s;
    logic            dec_arith_s;
    logic [XLEN-1:0] dec_op1_s;
    logic [XLEN-1:0] dec_op2_s;
    logic [4:0]      dec_rd_s;

    logic            cond_s;
    logic            taken_s;
    logic            wen_s;
    logic [XLEN-1:0] wdata_s;

    // Register-index fields are resolved upstream, so the rs1 index bits are not consumed here.
    logic            unused_s;
    assign unused_s = ^i_inst[19:15];

    assign opcode_s = i_inst[6:0];
    assign funct3_s = i_inst[14:12];
    assign funct7_s = i_inst[31:25];

    // Raw decode of the incoming instruction, before illegal encodings are squashed.
    always_comb begin
        raw_cls_s      = CLS_NONE;
        raw_illegal_s  = 1'b1;
        raw_opsel_s    = 3'b000;
        raw_sub_s      = 1'b0;
        raw_unsigned_s = 1'b0;
        raw_arith_s    = 1'b0;
        raw_op1_s      = {XLEN{1'b0}};
        raw_op2_s      = {XLEN{1'b0}};
        case (opcode_s)
            OPC_OP: begin
                raw_cls_s      = CLS_ALU;
                raw_opsel_s    = funct3_s;
                raw_op1_s      = i_rs1_data;
                raw_op2_s      = i_rs2_data;
                raw_sub_s      = (funct3_s == 3'b000) & funct7_s[5];
                raw_arith_s    = (funct3_s == 3'b101) & funct7_s[5];
                raw_unsigned_s = (funct3_s == 3'b011);
                if (funct7_s == 7'b0000000) begin
                    raw_illegal_s = 1'b0;
                end else if ((funct7_s == 7'b0100000) &&
                             ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
                    raw_illegal_s = 1'b0;
                end else begin
                    raw_illegal_s = 1'b1;
                end
            end
            OPC_OPIMM: begin
                raw_cls_s      = CLS_ALU;
                raw_opsel_s    = funct3_s;
                raw_op1_s      = i_rs1_data;
                raw_arith_s    = (funct3_s == 3'b101) & i_inst[30];
                raw_unsigned_s = (funct3_s == 3'b011);
                // Shifts take a 5-bit shamt; everything else takes the sign-extended I-immediate.
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    raw_op2_s = {{(XLEN-5){1'b0}}, i_inst[24:20]};
                end else begin
                    raw_op2_s = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
                end
                case (funct3_s)
                    3'b001:  raw_illegal_s = (funct7_s != 7'b0000000);
                    3'b101:  raw_illegal_s = (funct7_s != 7'b0000000) &&
                                             (funct7_s != 7'b0100000);
                    default: raw_illegal_s = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                raw_cls_s      = CLS_BRANCH;
                raw_opsel_s    = 3'b000;
                raw_sub_s      = 1'b1;
                raw_unsigned_s = funct3_s[1];
                raw_op1_s      = i_rs1_data;
                raw_op2_s      = i_rs2_data;
                raw_illegal_s  = (funct3_s == 3'b010) || (funct3_s == 3'b011);
            end
            default: begin
                raw_cls_s     = CLS_NONE;
                raw_illegal_s = 1'b1;
            end
        endcase
    end

    // Illegal encodings present all-zero controls and operands to the ALU.
    assign dec_opsel_s    = raw_illegal_s ? 3'b000 : raw_opsel_s;
    assign dec_sub_s      = raw_illegal_s ? 1'b0 : raw_sub_s;
    assign dec_unsigned_s = raw_illegal_s ? 1'b0 : raw_unsigned_s;
    assign dec_arith_s    = raw_illegal_s ? 1'b0 : raw_arith_s;
    assign dec_op1_s      = raw_illegal_s ? {XLEN{1'b0}} : raw_op1_s;
    assign dec_op2_s      = raw_illegal_s ? {XLEN{1'b0}} : raw_op2_s;
    assign dec_rd_s       = (raw_cls_s == CLS_ALU) ? i_inst[11:7] : 5'd0;

    // Branch condition from the captured funct3 and the ALU compare flags.
    always_comb begin
        cond_s = 1'b0;
        case (funct3_r)
            3'b000:  cond_s = i_alu_eq;
            3'b001:  cond_s = ~i_alu_eq;
            3'b100:  cond_s = i_alu_slt;
            3'b101:  cond_s = ~i_alu_slt;
            3'b110:  cond_s = i_alu_slt;
            3'b111:  cond_s = ~i_alu_slt;
            default: cond_s = 1'b0;
        endcase
    end

    assign taken_s = ~illegal_r & (cls_r == CLS_BRANCH) & cond_s;
    assign wen_s   = ~illegal_r & (cls_r == CLS_ALU) & (rd_r != 5'd0);
    assign wdata_s = (~illegal_r & (cls_r == CLS_ALU)) ? i_alu_result : {XLEN{1'b0}};

    // Issue FSM: accept in IDLE, capture the ALU response in EXEC, hold the response in DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r        <= IDLE;
            cls_r          <= CLS_NONE;
            funct3_r       <= 3'b000;
            rd_r           <= 5'd0;
            illegal_r      <= 1'b0;
            o_ready        <= 1'b1;
            o_alu_opsel    <= 3'b000;
            o_alu_sub      <= 1'b0;
            o_alu_unsigned <= 1'b0;
            o_alu_arith    <= 1'b0;
            o_alu_op1      <= {XLEN{1'b0}};
            o_alu_op2      <= {XLEN{1'b0}};
            o_valid        <= 1'b0;
            o_rd_waddr     <= 5'd0;
            o_rd_wdata     <= {XLEN{1'b0}};
            o_rd_wen       <= 1'b0;
            o_branch_taken <= 1'b0;
            o_illegal      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid) begin
                        o_alu_opsel    <= dec_opsel_s;
                        o_alu_sub      <= dec_sub_s;
                        o_alu_unsigned <= dec_unsigned_s;
                        o_alu_arith    <= dec_arith_s;
                        o_alu_op1      <= dec_op1_s;
                        o_alu_op2      <= dec_op2_s;
                        cls_r          <= raw_cls_s;
                        funct3_r       <= funct3_s;
                        rd_r           <= dec_rd_s;
                        illegal_r      <= raw_illegal_s;
                        o_ready        <= 1'b0;
                        state_r        <= EXEC;
                    end else begin
                        o_ready <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    o_rd_waddr     <= rd_r;
                    o_rd_wdata     <= wdata_s;
                    o_rd_wen       <= wen_s;
                    o_branch_taken <= taken_s;
                    o_illegal      <= illegal_r;
                    o_valid        <= 1'b1;
                    state_r        <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed instructions push expected responses, a monitor checks them.
module tb_alu_issue;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        wen;
        logic        taken;
        logic        illegal;
    } resp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_inst = 32'd0;
    logic [31:0] i_rs1_data = 32'd0;
    logic [31:0] i_rs2_data = 32'd0;
    logic [2:0]  o_alu_opsel;
    logic        o_alu_sub, o_alu_unsigned, o_alu_arith;
    logic [31:0] o_alu_op1, o_alu_op2;
    logic [31:0] i_alu_result;
    logic        i_alu_eq, i_alu_slt;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [4:0]  o_rd_waddr;
    logic [31:0] o_rd_wdata;
    logic        o_rd_wen, o_branch_taken, o_illegal;

    int errors = 0;
    int checks = 0;
    resp_t exp_q[$];

    alu_issue #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_inst(i_inst), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .o_alu_opsel(o_alu_opsel), .o_alu_sub(o_alu_sub), .o_alu_unsigned(o_alu_unsigned),
        .o_alu_arith(o_alu_arith), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
        .i_alu_result(i_alu_result), .i_alu_eq(i_alu_eq), .i_alu_slt(i_alu_slt),
        .o_valid(o_valid), .i_ready(i_ready), .o_rd_waddr(o_rd_waddr),
        .o_rd_wdata(o_rd_wdata), .o_rd_wen(o_rd_wen), .o_branch_taken(o_branch_taken),
        .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Reference ALU the block drives
    always_comb begin
        case (o_alu_opsel)
            3'd0:    i_alu_result = o_alu_sub ? (o_alu_op1 - o_alu_op2) : (o_alu_op1 + o_alu_op2);
            3'd1:    i_alu_result = o_alu_op1 << o_alu_op2[4:0];
            3'd2:    i_alu_result = {31'd0, $signed(o_alu_op1) < $signed(o_alu_op2)};
            3'd3:    i_alu_result = {31'd0, o_alu_op1 < o_alu_op2};
            3'd4:    i_alu_result = o_alu_op1 ^ o_alu_op2;
            3'd5:    i_alu_result = o_alu_arith ? 32'($signed(o_alu_op1) >>> o_alu_op2[4:0])
                                                : (o_alu_op1 >> o_alu_op2[4:0]);
            3'd6:    i_alu_result = o_alu_op1 | o_alu_op2;
            default: i_alu_result = o_alu_op1 & o_alu_op2;
        endcase
        i_alu_eq  = (o_alu_op1 == o_alu_op2);
        i_alu_slt = o_alu_unsigned ? (o_alu_op1 < o_alu_op2)
                                   : ($signed(o_alu_op1) < $signed(o_alu_op2));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented response is compared with the queue head; popped when consumed.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got o_valid=1 expected no response");
            end else begin
                check("resp_waddr", {27'd0, o_rd_waddr}, {27'd0, exp_q[0].waddr});
                check("resp_wdata", o_rd_wdata, exp_q[0].wdata);
                check("resp_wen", {31'd0, o_rd_wen}, {31'd0, exp_q[0].wen});
                check("resp_taken", {31'd0, o_branch_taken}, {31'd0, exp_q[0].taken});
                check("resp_illegal", {31'd0, o_illegal}, {31'd0, exp_q[0].illegal});
                if (i_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input string name, input logic [31:0] inst, input logic [31:0] rs1,
                         input logic [31:0] rs2, input resp_t exp, input logic [2:0] e_opsel,
                         input logic e_sub, input logic e_uns, input logic e_arith,
                         input logic [31:0] e_op1, input logic [31:0] e_op2);
        int n = 0;
        @(negedge i_clk);
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check({name, "_ready_wait"}, {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1;
        i_inst = inst;
        i_rs1_data = rs1;
        i_rs2_data = rs2;
        exp_q.push_back(exp);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        check({name, "_exec_opsel"}, {29'd0, o_alu_opsel}, {29'd0, e_opsel});
        check({name, "_exec_ctl"}, {29'd0, o_alu_sub, o_alu_unsigned, o_alu_arith},
              {29'd0, e_sub, e_uns, e_arith});
        check({name, "_exec_op1"}, o_alu_op1, e_op1);
        check({name, "_exec_op2"}, o_alu_op2, e_op2);
        check({name, "_exec_ready"}, {30'd0, o_ready, o_valid}, 32'd0);
        @(negedge i_clk);
        check({name, "_latency"}, {31'd0, o_valid}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_timeout", {31'd0, n >= 50}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_ready_valid", {30'd0, o_ready, o_valid}, 32'd2);
        check("rst_alu_ctl", {26'd0, o_alu_opsel, o_alu_sub, o_alu_unsigned, o_alu_arith}, 32'd0);
        check("rst_alu_ops", o_alu_op1 | o_alu_op2, 32'd0);
        check("rst_resp", {o_rd_waddr, o_rd_wen, o_branch_taken, o_illegal} | o_rd_wdata, 32'd0);

        issue("sub", 32'h402081B3, 32'd5, 32'd6, '{5'd3, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0},
              3'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd6);
        drain();
        @(negedge i_clk);
        check("sub_back_idle", {30'd0, o_ready, o_valid}, 32'd2);
        issue("srai", 32'h4020D293, 32'hFFFFFFFB, 32'd0, '{5'd5, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0},
              3'd5, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFB, 32'd2);
        issue("bltu", 32'h0020E063, 32'hFFFFFFFB, 32'd3, '{5'd0, 32'd0, 1'b0, 1'b0, 1'b0},
              3'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFB, 32'd3);
        issue("blt", 32'h0020C063, 32'hFFFFFFFB, 32'd3, '{5'd0, 32'd0, 1'b0, 1'b1, 1'b0},
              3'd0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFB, 32'd3);
        issue("beq", 32'h00208063, 32'd7, 32'd7, '{5'd0, 32'd0, 1'b0, 1'b1, 1'b0},
              3'd0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd7);
        issue("bne", 32'h00209063, 32'd7, 32'd7, '{5'd0, 32'd0, 1'b0, 1'b0, 1'b0},
              3'd0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd7);
        issue("sltu", 32'h0020B3B3, 32'hFFFFFFFB, 32'd3, '{5'd7, 32'd0, 1'b1, 1'b0, 1'b0},
              3'd3, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFB, 32'd3);
        issue("slt", 32'h0020A3B3, 32'hFFFFFFFB, 32'd3, '{5'd7, 32'd1, 1'b1, 1'b0, 1'b0},
              3'd2, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFB, 32'd3);
        issue("addi_x0", 32'h00508013, 32'd1, 32'd0, '{5'd0, 32'd6, 1'b0, 1'b0, 1'b0},
              3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd5);
        issue("addi_neg", 32'hFFF08113, 32'd10, 32'd0, '{5'd2, 32'd9, 1'b1, 1'b0, 1'b0},
              3'd0, 1'b0, 1'b0, 1'b0, 32'd10, 32'hFFFFFFFF);
        issue("ill_opc", 32'h0000007F, 32'd1, 32'd2, '{5'd0, 32'd0, 1'b0, 1'b0, 1'b1},
              3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        issue("ill_slli", 32'h02309313, 32'd1, 32'd2, '{5'd6, 32'd0, 1'b0, 1'b0, 1'b1},
              3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        issue("ill_br", 32'h0020A063, 32'd1, 32'd2, '{5'd0, 32'd0, 1'b0, 1'b0, 1'b1},
              3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        issue("ill_op", 32'h40209233, 32'd1, 32'd2, '{5'd4, 32'd0, 1'b0, 1'b0, 1'b1},
              3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drain();

        // Backpressure: hold the response for 5 cycles with a second request waiting.
        @(posedge i_clk);
        #1 i_ready = 1'b0;
        issue("bp_add", 32'h00208233, 32'd10, 32'd20, '{5'd4, 32'd30, 1'b1, 1'b0, 1'b0},
              3'd0, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20);
        i_valid = 1'b1;
        i_inst = 32'h0020F4B3;
        i_rs1_data = 32'h0000F0F0;
        i_rs2_data = 32'h0000FF00;
        exp_q.push_back('{5'd9, 32'h0000F000, 1'b1, 1'b0, 1'b0});
        repeat (5) begin
            @(negedge i_clk);
            check("bp_ready_low", {30'd0, o_ready, o_valid}, 32'd1);
        end
        @(posedge i_clk);
        #1 i_ready = 1'b1;
        @(negedge i_clk);
        check("bp_retire_cycle", {30'd0, o_ready, o_valid}, 32'd1);
        @(negedge i_clk);
        check("bp_idle", {30'd0, o_ready, o_valid}, 32'd2);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        @(negedge i_clk);
        check("bp_accepted", {31'd0, o_ready}, 32'd0);
        check("bp_and_op2", o_alu_op2, 32'h0000FF00);
        drain();

        // Reset while in EXEC drops the instruction.
        @(negedge i_clk);
        i_valid = 1'b1;
        i_inst = 32'h00208233;
        i_rs1_data = 32'd1;
        i_rs2_data = 32'd2;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            check("rst_exec_no_valid", {30'd0, o_ready, o_valid}, 32'd2);
        end
        check("rst_exec_ops", o_alu_op1 | o_alu_op2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
